// File: rtl/csr_fifo_regs_if.sv
// CSR bus between the SPI CSR master and csr_fifo_regs.
// Carries address, read/write strobes and the two data buses.
interface csr_fifo_regs_if #(
    parameter int A_WIDTH = 5
) ();
    logic [A_WIDTH-1:0] csr_address;
    logic               csr_read;
    logic [7:0]         csr_readdata;
    logic               csr_write;
    logic [7:0]         csr_writedata;

    modport master (
        output csr_address,
        output csr_read,
        input  csr_readdata,
        output csr_write,
        output csr_writedata
    );

    modport slave (
        input  csr_address,
        input  csr_read,
        output csr_readdata,
        input  csr_write,
        input  csr_writedata
    );
endinterface

// File: rtl/csr_fifo_regs.sv
// CSR block fronting a byte FIFO fed by the pixel capture side.
// Optional macro CSR_IRQ_EN adds CTRL.irq_en and the registered irq output.
module csr_fifo_regs #(
    parameter int A_WIDTH    = 5,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    csr_fifo_regs_if.slave       csr,
    input  logic                 pix_valid,
    input  logic [7:0]           pix_data,
    output logic                 cap_en
`ifdef CSR_IRQ_EN
    ,
    output logic                 irq
`endif
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]  FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [A_WIDTH-1:0]   ADDR_ID     = A_WIDTH'(0);
    localparam logic [A_WIDTH-1:0]   ADDR_CTRL   = A_WIDTH'(1);
    localparam logic [A_WIDTH-1:0]   ADDR_STATUS = A_WIDTH'(2);
    localparam logic [A_WIDTH-1:0]   ADDR_LEVEL  = A_WIDTH'(3);
    localparam logic [A_WIDTH-1:0]   ADDR_DATA   = A_WIDTH'(4);
    localparam logic [7:0]           ID_VALUE    = 8'hCA;

    logic [7:0]            mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
    logic [DEPTH_LOG2:0]   count_r, count_nxt_s;
    logic                  cap_en_r, ovf_r, unf_r;
    logic [7:0]            readdata_r, rd_mux_s, level_s;
    logic                  empty_s, full_s, push_s, pop_s, flush_s;
    logic                  ovf_set_s, unf_set_s, ovf_clr_s, unf_clr_s;
    logic                  wr_ctrl_s, wr_status_s, rd_data_s, irq_en_s;
    logic [A_WIDTH-1:0]    addr_s;

    assign addr_s  = csr.csr_address;
    assign empty_s = (count_r == (DEPTH_LOG2 + 1)'(0));
    assign full_s  = (count_r == FULL_COUNT);
    assign level_s = 8'(count_r);

    // Decode strobes into FIFO and flag actions.
    always_comb begin
        wr_ctrl_s   = csr.csr_write & (addr_s == ADDR_CTRL);
        wr_status_s = csr.csr_write & (addr_s == ADDR_STATUS);
        rd_data_s   = csr.csr_read  & (addr_s == ADDR_DATA);
        flush_s     = wr_ctrl_s & csr.csr_writedata[7];
        pop_s       = rd_data_s & ~empty_s;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
        push_s      = pix_valid & cap_en_r & (~full_s | pop_s);
        ovf_set_s   = pix_valid & cap_en_r & full_s & ~pop_s;
        unf_set_s   = rd_data_s & empty_s;
        ovf_clr_s   = wr_status_s & csr.csr_writedata[2];
        unf_clr_s   = wr_status_s & csr.csr_writedata[3];
    end

    // Next pointer and occupancy; flush overrides push and pop.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        if (flush_s) begin
            wr_ptr_nxt_s = '0;
            rd_ptr_nxt_s = '0;
            count_nxt_s  = '0;
        end else begin
            if (push_s) begin
                wr_ptr_nxt_s = wr_ptr_r + DEPTH_LOG2'(1);
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + DEPTH_LOG2'(1);
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            if (push_s && !pop_s) begin
                count_nxt_s = count_r + (DEPTH_LOG2 + 1)'(1);
            end else if (pop_s && !push_s) begin
                count_nxt_s = count_r - (DEPTH_LOG2 + 1)'(1);
            end else begin
                count_nxt_s = count_r;
            end
        end
    end

    // Read mux over current (pre-write) register values.
    always_comb begin
        rd_mux_s = 8'h00;
        case (addr_s)
            ADDR_ID:     rd_mux_s = ID_VALUE;
            ADDR_CTRL:   rd_mux_s = {6'b000000, irq_en_s, cap_en_r};
            ADDR_STATUS: rd_mux_s = {4'b0000, unf_r, ovf_r, full_s, empty_s};
            ADDR_LEVEL:  rd_mux_s = level_s;
            ADDR_DATA: begin
                if (empty_s) begin
                    rd_mux_s = 8'h00;
                end else begin
                    rd_mux_s = mem_r[rd_ptr_r];
                end
            end
            default:     rd_mux_s = 8'h00;
        endcase
    end

    // Control, status and FIFO bookkeeping registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            cap_en_r   <= 1'b0;
            ovf_r      <= 1'b0;
            unf_r      <= 1'b0;
            readdata_r <= 8'h00;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            // Set beats a simultaneous write-1-to-clear.
            ovf_r    <= ovf_set_s | (ovf_r & ~ovf_clr_s);
            unf_r    <= unf_set_s | (unf_r & ~unf_clr_s);
            if (wr_ctrl_s) begin
                cap_en_r <= csr.csr_writedata[0];
            end else begin
                cap_en_r <= cap_en_r;
            end
            if (csr.csr_read) begin
                readdata_r <= rd_mux_s;
            end else begin
                readdata_r <= readdata_r;
            end
        end
    end

    // FIFO storage is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (push_s && !flush_s) begin
            mem_r[wr_ptr_r] <= pix_data;
        end
    end

`ifdef CSR_IRQ_EN
    logic irq_en_r, irq_r;
    assign irq_en_s = irq_en_r;

    // Interrupt enable bit and level interrupt register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en_r <= 1'b0;
            irq_r    <= 1'b0;
        end else begin
            if (wr_ctrl_s) begin
                irq_en_r <= csr.csr_writedata[1];
            end else begin
                irq_en_r <= irq_en_r;
            end
            irq_r <= irq_en_r & (~empty_s | ovf_r | unf_r);
        end
    end
    assign irq = irq_r;
`else
    assign irq_en_s = 1'b0;
`endif

    assign cap_en           = cap_en_r;
    assign csr.csr_readdata = readdata_r;
endmodule
